// File: rtl/bus_pkg.sv
// Shared slave-bus types and helpers used by initiators, slaves and the interconnect.
package bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } tsize_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_e;

  // Command payload for one single-beat transfer
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    tsize_e            tsize;
    ttype_e            ttype;
  } bus_req_t;

  // Completion payload returned to the requester
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              error;
    logic              timeout;
  } bus_rsp_t;

  // True when the low address bits are not a multiple of the transfer size
  function automatic logic is_misaligned(input logic [1:0] addr_lo, input tsize_e tsize);
    case (tsize)
      HALF:    return addr_lo[0];
      WORD:    return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Zero-extend low-lane read data to the transfer size
  function automatic logic [DATA_W-1:0] mask_rdata(input logic [DATA_W-1:0] data, input tsize_e tsize);
    case (tsize)
      BYTE:    return {24'h0, data[7:0]};
      HALF:    return {16'h0, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/slave_bus_if.sv
// Single-beat slave bus: the initiator drives the ic side, address-decoded slaves the sl side.
interface slave_bus_if;
  import bus_pkg::*;

  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] addr;
  logic              bstart;
  tsize_e            tsize;
  ttype_e            ttype;
  logic              ss;
  logic [DATA_W-1:0] rdata;
  logic              berror;
  logic              bdone;

  modport ic (
    output wdata, addr, bstart, tsize, ttype, ss,
    input  rdata, berror, bdone
  );

  modport sl (
    input  wdata, addr, bstart, tsize, ttype, ss,
    output rdata, berror, bdone
  );

endinterface

// File: rtl/slave_bus_initiator.sv
// Bus initiator: runs one valid/ready request at a time on the slave bus and returns
// exactly one response per request (data, slave error, misalignment or timeout).
module slave_bus_initiator
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        bclk,
  input  logic        brst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  tsize_e      req_tsize,
  input  ttype_e      req_ttype,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        rsp_timeout,
  slave_bus_if.ic     bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_e;

  state_e           state;
  bus_req_t         req_q;
  bus_rsp_t         rsp_q;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit_c;

  // Last WAIT cycle before abort
  assign timeout_hit_c = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Bus payload comes straight from the latched request so it stays stable through WAIT
  assign bus.addr  = req_q.addr;
  assign bus.wdata = req_q.wdata;
  assign bus.tsize = req_q.tsize;
  assign bus.ttype = req_q.ttype;

  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_error   = rsp_q.error;
  assign rsp_timeout = rsp_q.timeout;

  // Transfer FSM with registered handshake, bus strobes and response
  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_q      <= '0;
      cnt        <= '0;
      bus.bstart <= 1'b0;
      bus.ss     <= 1'b0;
      req_q      <= '{addr: '0, wdata: '0, tsize: WORD, ttype: READ};
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_q     <= '{addr: req_addr, wdata: req_wdata, tsize: req_tsize, ttype: req_ttype};
            req_ready <= 1'b0;
            if (is_misaligned(req_addr[1:0], req_tsize)) begin
              // Rejected locally, the bus never sees it
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_q     <= '{rdata: '0, error: 1'b1, timeout: 1'b0};
            end else begin
              state      <= S_START;
              bus.bstart <= 1'b1;
              bus.ss     <= 1'b1;
              cnt        <= '0;
            end
          end
        end

        S_START: begin
          bus.bstart <= 1'b0;
          state      <= S_WAIT;
        end

        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (bus.berror) begin
            state     <= S_RESP;
            bus.ss    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_q     <= '{rdata: '0, error: 1'b1, timeout: 1'b0};
          end else if (bus.bdone) begin
            state     <= S_RESP;
            bus.ss    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_q     <= '{rdata: (req_q.ttype == READ) ? mask_rdata(bus.rdata, req_q.tsize) : '0,
                           error: 1'b0, timeout: 1'b0};
          end else if (timeout_hit_c) begin
            state     <= S_RESP;
            bus.ss    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_q     <= '{rdata: '0, error: 1'b1, timeout: 1'b1};
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            req_ready <= 1'b1;
          end
        end

        default: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          rsp_valid  <= 1'b0;
          bus.bstart <= 1'b0;
          bus.ss     <= 1'b0;
        end
      endcase
    end
  end

endmodule
